sda_kernel_ctrl_multi: RTL
==========================

// Module: sda_kernel_ctrl_multi
// PURPOSE
//  SDAccel control-register block and run sequencer for NUM_CHANNELS action
//  cores sharing one kernel slave. Maps the ap_ctrl run/status interface onto
//  per-channel go/done SELF handshakes and adds auto-restart and interrupt
//  enable/status. Adds run counting and last-run cycle timing. Sits on the
//  reg_* bus beside the parameter memory; read data is OR-combined with it.
// PARAMETERS
//  ADDR_WIDTH    12  reg_addr width (byte address)
//  NUM_CHANNELS   4  action cores driven (1..32)
//  BASE_ADDR      0  byte base of the 32-byte register window (32-aligned)
// PORTS
//  clk           in   1     kernel clock
//  reset         in   1     synchronous, active-high
//  reg_req       in   1     register access request (single-cycle pulse)
//  reg_ack       out  1     access acknowledge
//  reg_write_en  in   1     1=write, 0=read
//  reg_addr      in   ADDR_WIDTH  byte address
//  reg_wdata     in   32    write data
//  reg_wstrb     in   4     byte strobes
//  reg_rdata     out  32    read data; 0 when not acking
//  go_valid      out  NUM_CHANNELS  per-channel go Ready
//  go_stop       in   NUM_CHANNELS  per-channel go Stop
//  done_valid    in   NUM_CHANNELS  per-channel done Ready
//  done_stop     out  NUM_CHANNELS  per-channel done Stop
//  interrupt     out  1     level interrupt to host
// BEHAVIOUR
//  Reset: reg_ack=0, reg_rdata=0, go_valid=0, done_stop=all 1, interrupt=0;
//   all regs 0 except ap_idle=1; FSM=IDLE. Mid-run reset abandons the run.
//  Access: hit = reg_req && addr in [BASE,BASE+0x1F]; reg_ack and reg_rdata
//   registered, valid exactly 1 cycle after reg_req; misses never ack.
//  Map (offset): 00 CTRL b0 ap_start b1 ap_done(clear-on-read) b2 ap_idle
//   b3 ap_ready(clear-on-read) b7 auto_restart; 04 GIE b0; 08 IER b0 done,
//   b1 ready; 0C ISR b0 done, b1 ready (write 1 toggles); 10 RUN_COUNT (RO);
//   14 LAST_CYCLES (RO); 18,1C read 0. Writes honour wstrb; RO bits ignored.
//  SELF transfer on channel i when go_valid[i] && !go_stop[i] (same for done).
//  FSM:
//   IDLE: ap_start write of 1 -> GO; ap_idle cleared, cycle counter = 0.
//   GO: go_valid[i]=!go_taken[i]; when all taken -> RUN, ap_start cleared,
//    ap_ready set, ISR.b1 set if IER.b1.
//   RUN (also during GO): done_stop[i]=!(go_taken[i] && !done_taken[i]);
//    when all done_taken -> DONE.
//   DONE (1 cycle): ap_done=1, RUN_COUNT+=1 (wraps), LAST_CYCLES=counter,
//    ISR.b0 set if IER.b0; auto_restart ? GO (ap_start held 1) : IDLE, ap_idle=1.
//  Cycle counter runs from GO entry to DONE, saturates at 0xFFFF_FFFF.
//  ap_start writes outside IDLE ignored; writing 0 never aborts a run.
//  Same-cycle set and clear: hardware set wins (ISR = (ISR^toggle)|set;
//   ap_done/ap_ready stay 1 if set on the clearing read).
//  interrupt registered: GIE && |(ISR & IER), 1-cycle latency.
// TESTING
//  NUM_CHANNELS=4, no stalls: write CTRL=1, all done 5 cycles after go ->
//   CTRL reads 0x0E then 0x04; RUN_COUNT=1.
//  Staggered go_stop (ch2 held 10 cycles): go_valid[2] held, ap_ready only
//   after ch2 accepts; done_stop[2]=1 until its go is taken.
//  Interrupts: GIE=1, IER=3, run -> interrupt 1 cycle after ISR sets;
//   write ISR=1 -> ISR=2, interrupt stays 1; write ISR=2 -> interrupt drops.
//  auto_restart=1: three back-to-back runs with no host writes; RUN_COUNT=3;
//   clear b7 mid-run -> returns to IDLE after the current run.
//  Reset asserted in RUN: next cycle go_valid=0, done_stop=0xF, CTRL=0x04.
//  Access at BASE+0x20 and wstrb=0 write to CTRL: no ack / no change.

Source files
------------

// File: rtl/sda_kernel_ctrl_multi.sv
// Kernel control/status register window and run sequencer for a group of action
// cores sharing one kernel slave: ap_ctrl run semantics mapped onto per-channel go/done handshakes.
module sda_kernel_ctrl_multi #(
  parameter int                    ADDR_WIDTH   = 12,
  parameter int                    NUM_CHANNELS = 4,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR    = '0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    reg_req,
  output logic                    reg_ack,
  input  logic                    reg_write_en,
  input  logic [ADDR_WIDTH-1:0]   reg_addr,
  input  logic [31:0]             reg_wdata,
  input  logic [3:0]              reg_wstrb,
  output logic [31:0]             reg_rdata,
  output logic [NUM_CHANNELS-1:0] go_valid,
  input  logic [NUM_CHANNELS-1:0] go_stop,
  input  logic [NUM_CHANNELS-1:0] done_valid,
  output logic [NUM_CHANNELS-1:0] done_stop,
  output logic                    interrupt
);

  typedef enum logic [1:0] {IDLE, GO, RUN, DONE} state_t;

  state_t state, state_next;

  logic                    ap_start, ap_done, ap_idle, ap_ready, auto_restart;
  logic                    gie;
  logic [1:0]              ier, isr, isr_set, isr_toggle;
  logic [31:0]             run_count, last_cycles, cycle_cnt, rd_data;
  logic [NUM_CHANNELS-1:0] go_taken, done_taken, go_fire, done_fire;
  logic                    hit, byte0_wr, ctrl_rd, start_req;
  logic                    all_go, all_done, enter_go, enter_run;
  logic [2:0]              offset;
  logic                    unused_bits;

  assign hit       = reg_req && (reg_addr[ADDR_WIDTH-1:5] == BASE_ADDR[ADDR_WIDTH-1:5]);
  assign offset    = reg_addr[4:2];
  assign byte0_wr  = hit && reg_write_en && reg_wstrb[0];
  assign ctrl_rd   = hit && !reg_write_en && (offset == 3'd0);
  assign start_req = byte0_wr && (offset == 3'd0) && reg_wdata[0];

  assign unused_bits = ^{reg_addr[1:0], reg_wdata[31:8], reg_wdata[6:2], reg_wstrb[3:1]};

  // A core may only hand back done once its go has been taken and until that done is taken.
  assign go_valid  = (state == GO) ? ~go_taken : '0;
  assign done_stop = ~(go_taken & ~done_taken);
  assign go_fire   = go_valid & ~go_stop;
  assign done_fire = done_valid & ~done_stop;

  assign all_go    = &(go_taken | go_fire);
  assign all_done  = &(done_taken | done_fire);
  assign enter_run = (state == GO) && all_go;
  assign enter_go  = ((state == IDLE) && start_req) || ((state == DONE) && auto_restart);

  assign isr_set    = {enter_run && ier[1], (state == DONE) && ier[0]};
  assign isr_toggle = (byte0_wr && (offset == 3'd3)) ? reg_wdata[1:0] : 2'b00;

  always_comb begin
    rd_data = '0;
    unique case (offset)
      3'd0:    rd_data = {24'd0, auto_restart, 3'd0, ap_ready, ap_idle, ap_done, ap_start};
      3'd1:    rd_data = {31'd0, gie};
      3'd2:    rd_data = {30'd0, ier};
      3'd3:    rd_data = {30'd0, isr};
      3'd4:    rd_data = run_count;
      3'd5:    rd_data = last_cycles;
      default: rd_data = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (start_req) state_next = GO;
      GO:      if (all_go) state_next = RUN;
      RUN:     if (all_done) state_next = DONE;
      DONE:    state_next = auto_restart ? GO : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Hardware set events take priority over clear-on-read and host toggles.
  always_ff @(posedge clk) begin
    if (reset) begin
      reg_ack      <= 1'b0;
      reg_rdata    <= '0;
      interrupt    <= 1'b0;
      ap_start     <= 1'b0;
      ap_done      <= 1'b0;
      ap_idle      <= 1'b1;
      ap_ready     <= 1'b0;
      auto_restart <= 1'b0;
      gie          <= 1'b0;
      ier          <= '0;
      isr          <= '0;
      run_count    <= '0;
      last_cycles  <= '0;
      cycle_cnt    <= '0;
      go_taken     <= '0;
      done_taken   <= '0;
    end else begin
      reg_ack   <= hit;
      reg_rdata <= (hit && !reg_write_en) ? rd_data : '0;
      interrupt <= gie && |(isr & ier);
      isr       <= (isr ^ isr_toggle) | isr_set;

      if (byte0_wr && (offset == 3'd0)) auto_restart <= reg_wdata[7];
      if (byte0_wr && (offset == 3'd1)) gie          <= reg_wdata[0];
      if (byte0_wr && (offset == 3'd2)) ier          <= reg_wdata[1:0];

      if ((state == GO) || (state == RUN)) begin
        go_taken   <= go_taken | go_fire;
        done_taken <= done_taken | done_fire;
        if (cycle_cnt != '1) cycle_cnt <= cycle_cnt + 32'd1;
      end

      if (enter_run) begin
        ap_start <= 1'b0;
        ap_ready <= 1'b1;
      end else if (ctrl_rd) begin
        ap_ready <= 1'b0;
      end

      if (state == DONE) begin
        ap_done     <= 1'b1;
        run_count   <= run_count + 32'd1;
        last_cycles <= cycle_cnt;
        if (!auto_restart) ap_idle <= 1'b1;
      end else if (ctrl_rd) begin
        ap_done <= 1'b0;
      end

      if (enter_go) begin
        ap_start   <= 1'b1;
        ap_idle    <= 1'b0;
        cycle_cnt  <= '0;
        go_taken   <= '0;
        done_taken <= '0;
      end
    end
  end

endmodule
